// File: rtl/bft_pkg.sv
// Shared BFT packet layout, control-port constant and transmit FSM state type.
package bft_pkg;
  localparam int PKT_VALID_BIT = 48;
  localparam int PKT_LEAF_LSB  = 43;
  localparam int PKT_PORT_LSB  = 39;
  localparam int PKT_ADDR_LSB  = 32;
  localparam int PKT_PAY_LSB   = 0;
  localparam int CTRL_PORT     = 0;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} tx_state_e;
endpackage

// File: rtl/leaf_tx_credit.sv
// Remote receive-buffer credit counter fed by freespace-update packets from the BFT.
module leaf_tx_credit
  import bft_pkg::*;
#(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int SELF_LEAF             = 0,
  parameter int DEST_PORT             = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] pkt_i,
  input  logic                   dec_i,
  output logic                   credit_ok_o,
  output logic                   credit_err_o
);
  localparam int CW       = NUM_ADDR_BITS + 1;
  localparam int PORT_LSB = PAYLOAD_BITS + NUM_ADDR_BITS;
  localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;
  localparam logic [CW:0] DEPTH = (CW+1)'(1 << NUM_ADDR_BITS);

  logic [CW-1:0] credit_q, credit_d;
  logic          err_q, err_d;
  logic          upd;
  logic [CW:0]   sum;
  logic          unused_pkt;

  assign unused_pkt = ^pkt_i[PORT_LSB-1:4];

  assign upd = pkt_i[PACKET_BITS-1]
            && (pkt_i[LEAF_LSB +: NUM_LEAF_BITS] == NUM_LEAF_BITS'(SELF_LEAF))
            && (pkt_i[PORT_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(CTRL_PORT))
            && (pkt_i[3:0] == 4'(DEST_PORT));

  // dec_i only fires with credit != 0, so the subtraction cannot underflow
  always_comb begin
    sum      = {1'b0, credit_q} + (upd ? (CW+1)'(FREESPACE_UPDATE_SIZE) : '0)
             - (CW+1)'(dec_i);
    credit_d = sum[CW-1:0];
    err_d    = err_q;
    if (sum > DEPTH) begin
      credit_d = DEPTH[CW-1:0];
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_q <= DEPTH[CW-1:0];
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign credit_ok_o  = (credit_q != '0);
  assign credit_err_o = err_q;
endmodule

// File: rtl/leaf_stream_packetizer.sv
// User-stream to BFT packetizer with remote-address stamping and resend hold.
// Credit tracking is built only when LEAF_TX_CREDIT_EN is defined.
module leaf_stream_packetizer
  import bft_pkg::*;
#(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int SELF_LEAF             = 0,
  parameter int DEST_LEAF             = 2,
  parameter int DEST_PORT             = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ap_start,
  input  logic [PAYLOAD_BITS-1:0] din_user,
  input  logic                    vld_user,
  output logic                    ack_user,
  input  logic [PACKET_BITS-1:0]  din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]  dout_leaf_interface2bft,
  input  logic                    resend,
  output logic                    credit_err
);
  tx_state_e                state_q, state_d;
  logic                     started_q, started_d;
  logic [NUM_ADDR_BITS-1:0] seq_q, seq_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic                     credit_ok;
  logic                     accept;

`ifdef LEAF_TX_CREDIT_EN
  leaf_tx_credit #(
    .PACKET_BITS          (PACKET_BITS),
    .PAYLOAD_BITS         (PAYLOAD_BITS),
    .NUM_LEAF_BITS        (NUM_LEAF_BITS),
    .NUM_PORT_BITS        (NUM_PORT_BITS),
    .NUM_ADDR_BITS        (NUM_ADDR_BITS),
    .FREESPACE_UPDATE_SIZE(FREESPACE_UPDATE_SIZE),
    .SELF_LEAF            (SELF_LEAF),
    .DEST_PORT            (DEST_PORT)
  ) u_credit (
    .clk         (clk),
    .reset       (reset),
    .pkt_i       (din_leaf_bft2interface),
    .dec_i       (accept),
    .credit_ok_o (credit_ok),
    .credit_err_o(credit_err)
  );
`else
  logic unused_leaf;
  assign unused_leaf = ^din_leaf_bft2interface;
  assign credit_ok   = 1'b1;
  assign credit_err  = 1'b0;
`endif

  // a held (resent) packet blocks new words so it is never overwritten
  assign accept   = started_q && vld_user && credit_ok && !((state_q == SEND) && resend);
  assign ack_user = accept;

  always_comb begin
    state_d   = state_q;
    started_d = started_q | ap_start;
    seq_d     = seq_q;
    dout_d    = dout_q;
    if (accept) begin
      dout_d  = {1'b1, NUM_LEAF_BITS'(DEST_LEAF), NUM_PORT_BITS'(DEST_PORT), seq_q, din_user};
      seq_d   = seq_q + NUM_ADDR_BITS'(1);
      state_d = SEND;
    end else if (state_q == SEND && !resend) begin
      dout_d[PACKET_BITS-1] = 1'b0;
      state_d               = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
      seq_q     <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      seq_q     <= seq_d;
      dout_q    <= dout_d;
    end
  end

  assign dout_leaf_interface2bft = dout_q;
endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Randomized scoreboard bench for leaf_stream_packetizer; model follows LEAF_TX_CREDIT_EN.
module tb_leaf_stream_packetizer;
  logic        clk = 1'b0;
  logic        reset, ap_start, vld_user, ack_user, resend, credit_err;
  logic [31:0] din_user;
  logic [48:0] din_leaf, dout;

  leaf_stream_packetizer dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .din_user(din_user),
    .vld_user(vld_user), .ack_user(ack_user), .din_leaf_bft2interface(din_leaf),
    .dout_leaf_interface2bft(dout), .resend(resend), .credit_err(credit_err));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [48:0] exp_q[$];

  // reference state: what the link should look like at the abstract level
  bit m_started, m_pend, m_err;
  int m_credit, m_words, n_acks;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: compare any packet on the link; it is consumed when resend is low
  always @(negedge clk) begin
    if (!reset && dout[48] === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_pkt", 64'(dout), 64'h0);
      else begin
        check("pkt", 64'(dout), 64'(exp_q[0]));
        if (!resend) void'(exp_q.pop_front());
      end
    end
  end

  function automatic bit is_update(input logic [48:0] p);
    return p[48] && p[47:43] == 5'd0 && p[42:39] == 4'd0 && p[3:0] == 4'd2;
  endfunction

  task automatic step(input bit ap, input bit v, input logic [31:0] d,
                      input bit rs, input logic [48:0] pkt);
    bit exp_ack;
    ap_start = ap; vld_user = v; din_user = d; resend = rs; din_leaf = pkt;
    @(negedge clk);
`ifdef LEAF_TX_CREDIT_EN
    exp_ack = m_started && v && m_credit > 0 && !(m_pend && rs);
`else
    exp_ack = m_started && v && !(m_pend && rs);
`endif
    check("ack_user", 64'(ack_user), 64'(exp_ack));
    check("dout_valid", 64'(dout[48]), 64'(m_pend));
    check("credit_err", 64'(credit_err), 64'(m_err));
    m_started = m_started | ap;
    if (exp_ack) begin
      exp_q.push_back({1'b1, 5'd2, 4'd2, 7'(m_words % 128), d});
      m_words++; n_acks++;
      m_credit--;
    end
    m_pend = exp_ack ? 1'b1 : (m_pend && rs);
`ifdef LEAF_TX_CREDIT_EN
    if (is_update(pkt)) begin
      m_credit += 64;
      if (m_credit > 128) begin m_credit = 128; m_err = 1'b1; end
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; vld_user = 1'b0; resend = 1'b0; din_leaf = '0; ap_start = 1'b0;
    din_user = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    m_started = 0; m_pend = 0; m_err = 0; m_credit = 128; m_words = 0;
    check("reset_dout", 64'(dout), 64'h0);
    check("reset_ack", 64'(ack_user), 64'h0);
    check("reset_err", 64'(credit_err), 64'h0);
  endtask

  function automatic logic [48:0] upd_pkt(input int kind);
    logic [31:0] pay = $urandom;
    case (kind)
      0: return {1'b1, 5'd0, 4'd0, 7'($urandom), pay[31:4], 4'd2};
      1: return {1'b1, 5'd0, 4'd0, 7'($urandom), pay[31:4], 4'd3};
      2: return {1'b1, 5'd3, 4'd0, 7'($urandom), pay[31:4], 4'd2};
      default: return {1'b0, 48'($urandom)};
    endcase
  endfunction

  initial begin
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 1, $urandom, 0, '0);
    step(1, 1, 32'h1234_5678, 0, '0);
    // run past the remote depth without updates
    for (int i = 0; i < 130; i++) step(0, 1, $urandom, 0, '0);
    step(0, 1, $urandom, 0, {1'b1, 5'd0, 4'd0, 7'd9, 32'h2});
    for (int i = 0; i < 70; i++) step(0, 1, $urandom, 0, '0);
    // directed resend hold
    do_reset();
    step(1, 0, '0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 1, $urandom, 0, '0);
    step(0, 1, 32'hA5A5_A5A5, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 1, $urandom, 1, '0);
    step(0, 1, 32'h0000_0006, 0, '0);
    step(0, 0, '0, 0, '0);
    // credit near empty, then update coincident with acceptance and ignored updates
    do_reset();
    step(1, 0, '0, 0, '0);
    for (int i = 0; i < 118; i++) step(0, 1, $urandom, 0, '0);
    step(0, 1, $urandom, 0, upd_pkt(0));
    step(0, 0, '0, 0, upd_pkt(1));
    step(0, 0, '0, 0, upd_pkt(2));
    n_acks = 0;
    for (int i = 0; i < 80; i++) step(0, 1, $urandom, 0, '0);
`ifdef LEAF_TX_CREDIT_EN
    check("acks_after_update", 64'(n_acks), 64'd73);
`else
    check("acks_after_update", 64'(n_acks), 64'd80);
`endif
    // saturation: two updates with most credit in hand
    do_reset();
    step(1, 0, '0, 0, '0);
    for (int i = 0; i < 28; i++) step(0, 1, $urandom, 0, '0);
    step(0, 0, '0, 0, upd_pkt(0));
    step(0, 0, '0, 0, upd_pkt(0));
    for (int i = 0; i < 5; i++) step(0, 1, $urandom, 0, '0);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(0, ($urandom % 4) != 0, $urandom, ($urandom % 5) == 0, upd_pkt($urandom % 10));
    // reset mid-packet, then the next word restarts at address 0
    step(0, 1, $urandom, 1, '0);
    do_reset();
    step(1, 0, '0, 0, '0);
    step(0, 1, 32'hCAFE_0000, 0, '0);
    step(0, 0, '0, 0, '0);
    step(0, 0, '0, 0, '0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
